// File: rtl/mem_io_bridge_if.sv
// Bus bundle between the CPU datapath, the load/store bridge, data RAM and IO.
// The bridge uses the slave view; the core/memory environment uses the master view.
interface mem_io_bridge_if #(
   parameter int IO_CHANNELS = 4
);
   // CPU request / response
   logic                       req_valid;
   logic                       req_write;
   logic [1:0]                 req_size;
   logic                       req_unsigned;
   logic [31:0]                addr_in;
   logic [31:0]                wdata_in;
   logic                       busy;
   logic                       done;
   logic                       err;
   logic [31:0]                rdata_out;

   // Synchronous data RAM port
   logic                       mem_en;
   logic                       mem_we;
   logic [3:0]                 mem_be;
   logic [31:0]                mem_addr;
   logic [31:0]                mem_wdata;
   logic [31:0]                mem_rdata;

   // Memory-mapped IO channels
   logic [IO_CHANNELS-1:0]     io_sel;
   logic                       io_rd;
   logic                       io_we;
   logic [15:0]                io_wdata;
   logic [16*IO_CHANNELS-1:0]  io_rdata;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, addr_in, wdata_in,
      input  mem_rdata, io_rdata,
      output busy, done, err, rdata_out,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output io_sel, io_rd, io_we, io_wdata
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, addr_in, wdata_in,
      output mem_rdata, io_rdata,
      input  busy, done, err, rdata_out,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  io_sel, io_rd, io_we, io_wdata
   );
endinterface

// File: rtl/mem_io_bridge.sv
// Registered load/store bridge: decodes each CPU access to data RAM or one of
// IO_CHANNELS IO windows, steers byte/half/word lanes, sign/zero-extends loads
// and holds the core with busy until a one-cycle done pulse.
module mem_io_bridge #(
   parameter int          IO_CHANNELS    = 4,
   parameter logic [31:0] IO_BASE        = 32'hFFFF_FC00,
   parameter int          IO_STRIDE_LOG2 = 4,
   parameter int          IO_WAIT        = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   mem_io_bridge_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCESS,
      S_MEM_RESP,
      S_IO_HOLD,
      S_FINISH
   } state_e;

   state_e state_q, state_d;

   // Registered outputs
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   mem_en_q, mem_en_d;
   logic                   mem_we_q, mem_we_d;
   logic [3:0]             mem_be_q, mem_be_d;
   logic [31:0]            mem_addr_q, mem_addr_d;
   logic [31:0]            mem_wdata_q, mem_wdata_d;
   logic [IO_CHANNELS-1:0] io_sel_q, io_sel_d;
   logic                   io_rd_q, io_rd_d;
   logic                   io_we_q, io_we_d;
   logic [15:0]            io_wdata_q, io_wdata_d;

   // Latched request and access bookkeeping
   logic                   write_q, write_d;
   logic [1:0]             size_q, size_d;
   logic                   uns_q, uns_d;
   logic [1:0]             lane_q, lane_d;
   logic                   is_io_q, is_io_d;
   logic                   rej_q, rej_d;
   logic [3:0]             wait_q, wait_d;
   logic [31:0]            data_q, data_d;

   // Request decode
   logic [31:0]            ch_idx;
   logic                   req_is_io;
   logic                   misalign;
   logic                   req_err;
   logic [3:0]             req_be;
   logic [31:0]            req_wdata;
   logic [IO_CHANNELS-1:0] req_sel;

   // Load data paths
   logic [7:0]             byte_v;
   logic [15:0]            half_v;
   logic [31:0]            mem_load_val;
   logic [15:0]            io_word;
   logic [31:0]            io_load_val;

   // Decode the incoming request: target, legality, byte enables and store lanes.
   always_comb begin
      ch_idx    = (bus.addr_in - IO_BASE) >> IO_STRIDE_LOG2;
      req_is_io = (bus.addr_in >= IO_BASE);

      case (bus.req_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = bus.addr_in[0];
         2'b10:   misalign = |bus.addr_in[1:0];
         default: misalign = 1'b1;
      endcase
      req_err = misalign | (req_is_io & (ch_idx >= 32'(IO_CHANNELS)));

      // Size 11 is rejected above, so it never reaches the strobes.
      case (bus.req_size)
         2'b00: begin
            req_be    = 4'b0001 << bus.addr_in[1:0];
            req_wdata = {4{bus.wdata_in[7:0]}};
         end
         2'b01: begin
            req_be    = 4'b0011 << bus.addr_in[1:0];
            req_wdata = {2{bus.wdata_in[15:0]}};
         end
         default: begin
            req_be    = 4'hF;
            req_wdata = bus.wdata_in;
         end
      endcase

      req_sel = '0;
      for (int k = 0; k < IO_CHANNELS; k++) begin
         req_sel[k] = (ch_idx == 32'(k));
      end
   end

   // Extract and extend the addressed RAM lane; IO data is always zero-extended.
   always_comb begin
      case (lane_q)
         2'd0:    byte_v = bus.mem_rdata[7:0];
         2'd1:    byte_v = bus.mem_rdata[15:8];
         2'd2:    byte_v = bus.mem_rdata[23:16];
         default: byte_v = bus.mem_rdata[31:24];
      endcase
      half_v = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

      case (size_q)
         2'b00:   mem_load_val = uns_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
         2'b01:   mem_load_val = uns_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
         default: mem_load_val = bus.mem_rdata;
      endcase

      io_word = '0;
      for (int k = 0; k < IO_CHANNELS; k++) begin
         if (io_sel_q[k]) io_word = io_word | bus.io_rdata[16*k +: 16];
      end
      io_load_val = {16'h0, io_word};
   end

   // Next-state and next-output logic of the access sequencer.
   always_comb begin
      // NOTE: every _d gets a default first so no path leaves a variable
      // unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      io_sel_d    = io_sel_q;
      io_rd_d     = io_rd_q;
      io_we_d     = io_we_q;
      io_wdata_d  = io_wdata_q;
      write_d     = write_q;
      size_d      = size_q;
      uns_d       = uns_q;
      lane_d      = lane_q;
      is_io_d     = is_io_q;
      rej_d       = rej_q;
      wait_d      = wait_q;
      data_d      = data_q;

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               write_d = bus.req_write;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               lane_d  = bus.addr_in[1:0];
               is_io_d = req_is_io;
               rej_d   = req_err;
               if (req_err) begin
                  state_d = S_FINISH;
               end else begin
                  // Strobes are registered, so they rise together with ACCESS.
                  state_d = S_ACCESS;
                  if (req_is_io) begin
                     io_sel_d   = req_sel;
                     io_rd_d    = ~bus.req_write;
                     io_we_d    = bus.req_write;
                     io_wdata_d = bus.wdata_in[15:0];
                  end else begin
                     mem_en_d    = 1'b1;
                     mem_we_d    = bus.req_write;
                     mem_be_d    = req_be;
                     mem_addr_d  = {bus.addr_in[31:2], 2'b00};
                     mem_wdata_d = req_wdata;
                  end
               end
            end
         end

         S_ACCESS: begin
            if (is_io_q) begin
               if (IO_WAIT > 0) begin
                  state_d = S_IO_HOLD;
                  wait_d  = 4'(IO_WAIT - 1);
               end else begin
                  state_d    = S_FINISH;
                  data_d     = io_load_val;
                  io_sel_d   = '0;
                  io_rd_d    = 1'b0;
                  io_we_d    = 1'b0;
                  io_wdata_d = '0;
               end
            end else begin
               state_d     = write_q ? S_FINISH : S_MEM_RESP;
               mem_en_d    = 1'b0;
               mem_we_d    = 1'b0;
               mem_be_d    = '0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
            end
         end

         S_IO_HOLD: begin
            if (wait_q == 4'd0) begin
               // Last strobe cycle: sample the selected channel now.
               state_d    = S_FINISH;
               data_d     = io_load_val;
               io_sel_d   = '0;
               io_rd_d    = 1'b0;
               io_we_d    = 1'b0;
               io_wdata_d = '0;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end

         S_MEM_RESP: begin
            state_d = S_FINISH;
            data_d  = mem_load_val;
         end

         S_FINISH: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = rej_q;
            if (!write_q && !rej_q) rdata_d = data_q;
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // FSM state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, so register order inside the block cannot change behaviour.
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Output and request registers; reset clears every output and aborts an access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         io_sel_q    <= '0;
         io_rd_q     <= 1'b0;
         io_we_q     <= 1'b0;
         io_wdata_q  <= '0;
         write_q     <= 1'b0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         lane_q      <= '0;
         is_io_q     <= 1'b0;
         rej_q       <= 1'b0;
         wait_q      <= '0;
         data_q      <= '0;
      end else begin
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         io_sel_q    <= io_sel_d;
         io_rd_q     <= io_rd_d;
         io_we_q     <= io_we_d;
         io_wdata_q  <= io_wdata_d;
         write_q     <= write_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lane_q      <= lane_d;
         is_io_q     <= is_io_d;
         rej_q       <= rej_d;
         wait_q      <= wait_d;
         data_q      <= data_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.rdata_out = rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.io_sel    = io_sel_q;
   assign bus.io_rd     = io_rd_q;
   assign bus.io_we     = io_we_q;
   assign bus.io_wdata  = io_wdata_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: a small RAM/IO environment, a transaction
// level model predicting every output per cycle, and literal spot checks.
module tb_mem_io_bridge;

   localparam int          IO_CHANNELS    = 4;
   localparam logic [31:0] IO_BASE        = 32'hFFFF_FC00;
   localparam int          IO_STRIDE_LOG2 = 4;
   localparam int          IO_WAIT        = 1;

   logic clk = 1'b0;
   logic rst_n;

   mem_io_bridge_if #(.IO_CHANNELS(IO_CHANNELS)) bus ();

   mem_io_bridge #(
      .IO_CHANNELS   (IO_CHANNELS),
      .IO_BASE       (IO_BASE),
      .IO_STRIDE_LOG2(IO_STRIDE_LOG2),
      .IO_WAIT       (IO_WAIT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- environment: RAM and IO peripherals ----------------
   bit   [31:0] env_ram   [64];
   bit   [31:0] model_ram [64];
   logic [15:0] io_vals   [4];

   assign bus.io_rdata = {io_vals[3], io_vals[2], io_vals[1], io_vals[0]};

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_be[b]) env_ram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         end else begin
            bus.mem_rdata <= env_ram[bus.mem_addr[7:2]];
         end
      end
   end

   // ---------------- transaction-level model ----------------
   bit          chk_en = 0, in_rst = 0, active = 0;
   bit          m_io, m_err, m_wr;
   int          n = 0, d_cyc = 0, s_cyc = 0;
   logic [3:0]  e_be, e_sel;
   logic [31:0] e_addr, e_wdata, e_load;
   logic [15:0] e_iow;
   logic [31:0] model_rdata = '0;

   function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      if (a >= IO_BASE) return {16'h0, io_vals[(a - IO_BASE) >> IO_STRIDE_LOG2]};
      w = model_ram[a[7:2]];
      b = 8'(w >> (8 * a[1:0]));
      h = 16'(w >> (16 * a[1]));
      if (sz == 2'd0) return uns ? {24'h0, b} : {{24{b[7]}}, b};
      if (sz == 2'd1) return uns ? {16'h0, h} : {{16{h[15]}}, h};
      return w;
   endfunction

   always @(posedge clk) begin
      logic [31:0] a, w, ch;
      logic [1:0]  sz;
      if (!rst_n) begin
         active = 0; n = 0; d_cyc = 0; model_rdata = '0; in_rst = 1; chk_en = 1;
      end else begin
         in_rst = 0;
         if ((!active || n >= d_cyc) && bus.req_valid) begin
            a  = bus.addr_in;  w = bus.wdata_in;  sz = bus.req_size;
            m_wr = bus.req_write;
            m_io = (a >= IO_BASE);
            ch   = (a - IO_BASE) >> IO_STRIDE_LOG2;
            m_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
                    || (m_io && ch >= IO_CHANNELS);
            s_cyc = m_err ? 0 : (m_io ? 1 + IO_WAIT : 1);
            d_cyc = m_err ? 2 : (m_io ? 3 + IO_WAIT : (m_wr ? 3 : 4));
            e_be    = (sz == 2'd0) ? (4'b0001 << a[1:0]) : (sz == 2'd1) ? (4'b0011 << a[1:0]) : 4'hF;
            e_wdata = (sz == 2'd0) ? {4{w[7:0]}} : (sz == 2'd1) ? {2{w[15:0]}} : w;
            e_addr  = {a[31:2], 2'b00};
            e_iow   = w[15:0];
            e_sel   = (m_io && !m_err) ? 4'(1 << ch) : 4'h0;
            e_load  = m_err ? 32'h0 : exp_load(a, sz, bus.req_unsigned);
            if (m_wr && !m_err && !m_io)
               for (int b = 0; b < 4; b++)
                  if (e_be[b]) model_ram[a[7:2]][8*b +: 8] = e_wdata[8*b +: 8];
            active = 1; n = 1;
         end else if (active) begin
            n++;
            if (n == d_cyc && !m_wr && !m_err) model_rdata = e_load;
         end
      end
   end

   // Per-cycle comparison of all DUT outputs against the model.
   always @(negedge clk) begin
      bit strobe;
      if (chk_en) begin
         strobe = active && !m_err && n >= 1 && n <= s_cyc;
         check("busy",   32'(bus.busy),   32'(active && n < d_cyc));
         check("done",   32'(bus.done),   32'(active && n == d_cyc));
         check("err",    32'(bus.err),    32'(active && n == d_cyc && m_err));
         check("rdata",  bus.rdata_out,   model_rdata);
         check("mem_en", 32'(bus.mem_en), 32'(strobe && !m_io));
         check("mem_we", 32'(bus.mem_we), 32'(strobe && !m_io && m_wr));
         check("io_rd",  32'(bus.io_rd),  32'(strobe && m_io && !m_wr));
         check("io_we",  32'(bus.io_we),  32'(strobe && m_io && m_wr));
         check("io_sel", 32'(bus.io_sel), 32'((strobe && m_io) ? e_sel : 4'h0));
         if (strobe && !m_io) begin
            check("mem_be",    32'(bus.mem_be), 32'(e_be));
            check("mem_addr",  bus.mem_addr,    e_addr);
            check("mem_wdata", bus.mem_wdata,   e_wdata);
         end
         if (strobe && m_io && m_wr) check("io_wdata", 32'(bus.io_wdata), 32'(e_iow));
         if (in_rst) begin
            check("rst_mem_be",    32'(bus.mem_be),   32'h0);
            check("rst_mem_addr",  bus.mem_addr,      32'h0);
            check("rst_mem_wdata", bus.mem_wdata,     32'h0);
            check("rst_io_wdata",  32'(bus.io_wdata), 32'h0);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   logic [3:0]  cap_be, cap_sel;
   logic [31:0] cap_wd;
   logic        cap_en, cap_err;
   int          io_rd_cnt;

   // Issue one request in the current cycle; returns cycles from accept to done.
   task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] w,
                         input bit poke, output int lat);
      bit got;
      bus.req_valid = 1; bus.req_write = wr; bus.req_size = sz;
      bus.req_unsigned = uns; bus.addr_in = a; bus.wdata_in = w;
      @(posedge clk);
      lat = 0; got = 0; io_rd_cnt = 0; cap_err = 0;
      while (lat < 20 && !got) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            bus.req_valid = 0;
            cap_be = bus.mem_be; cap_wd = bus.mem_wdata; cap_sel = bus.io_sel; cap_en = bus.mem_en;
         end
         if (poke && lat == 2) begin
            bus.req_valid = 1; bus.req_write = 1; bus.req_size = 2'd2;
            bus.addr_in = 32'h30; bus.wdata_in = 32'hDEAD_BEEF;
         end
         if (poke && lat == 3) bus.req_valid = 0;
         if (bus.io_rd) io_rd_cnt++;
         if (bus.done) begin got = 1; cap_err = bus.err; end
      end
      check("done_seen", 32'(got), 32'd1);
   endtask

   initial begin
      int lat;
      io_vals[0] = 16'h1111; io_vals[1] = 16'h5A5A; io_vals[2] = 16'h9ABC; io_vals[3] = 16'h7777;
      rst_n = 0;
      bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_unsigned = 0;
      bus.addr_in = 0; bus.wdata_in = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // Word store then load back
      do_req(1, 2'd2, 0, 32'h10, 32'h1234_5678, 0, lat);
      check("sw_lat", lat, 3);   check("sw_be", 32'(cap_be), 32'hF);
      do_req(0, 2'd2, 0, 32'h10, 0, 0, lat);
      check("lw_lat", lat, 4);   check("lw_rdata", bus.rdata_out, 32'h1234_5678);

      // Byte/half loads with sign and zero extension
      do_req(1, 2'd2, 0, 32'h10, 32'h80FF_0000, 0, lat);
      do_req(0, 2'd0, 0, 32'h13, 0, 0, lat);
      check("lb_rdata", bus.rdata_out, 32'hFFFF_FF80);
      do_req(0, 2'd0, 1, 32'h13, 0, 0, lat);
      check("lbu_rdata", bus.rdata_out, 32'h0000_0080);
      do_req(0, 2'd1, 0, 32'h12, 0, 0, lat);
      check("lh_rdata", bus.rdata_out, 32'hFFFF_80FF);

      // Halfword store lane steering
      do_req(1, 2'd1, 0, 32'h22, 32'h0000_ABCD, 0, lat);
      check("sh_be", 32'(cap_be), 32'hC);  check("sh_wdata", cap_wd, 32'hABCD_ABCD);
      check("sh_rdata_kept", bus.rdata_out, 32'hFFFF_80FF);
      do_req(0, 2'd1, 1, 32'h22, 0, 0, lat);
      check("lhu_rdata", bus.rdata_out, 32'h0000_ABCD);

      // IO accesses
      do_req(0, 2'd2, 0, 32'hFFFF_FC10, 0, 0, lat);
      check("io_lw_sel", 32'(cap_sel), 32'h2);  check("io_lw_rdcnt", io_rd_cnt, 2);
      check("io_lw_lat", lat, 4);                check("io_lw_rdata", bus.rdata_out, 32'h0000_5A5A);
      do_req(0, 2'd0, 0, 32'hFFFF_FC21, 0, 0, lat);
      check("io_lb_rdata", bus.rdata_out, 32'h0000_9ABC);
      do_req(1, 2'd1, 0, 32'hFFFF_FC00, 32'h0000_4321, 0, lat);
      check("io_sh_lat", lat, 4);  check("io_sh_sel", 32'(cap_sel), 32'h1);

      // Rejected requests
      do_req(0, 2'd2, 0, 32'h2, 0, 0, lat);
      check("mis_lat", lat, 2);  check("mis_err", 32'(cap_err), 32'd1);
      check("mis_en", 32'(cap_en), 32'd0);  check("mis_rdata", bus.rdata_out, 32'h0000_9ABC);
      do_req(0, 2'd2, 0, 32'hFFFF_FC40, 0, 0, lat);
      check("ioch_lat", lat, 2);  check("ioch_err", 32'(cap_err), 32'd1);
      check("ioch_sel", 32'(cap_sel), 32'h0);
      do_req(0, 2'd3, 0, 32'h10, 0, 0, lat);
      check("sz11_err", 32'(cap_err), 32'd1);
      do_req(0, 2'd1, 0, 32'h11, 0, 0, lat);
      check("lh_odd_err", 32'(cap_err), 32'd1);

      // Request pulsed while busy must be ignored
      do_req(0, 2'd2, 0, 32'h20, 0, 1, lat);
      check("poke_lat", lat, 4);  check("poke_rdata", bus.rdata_out, 32'hABCD_0000);
      do_req(0, 2'd2, 0, 32'h30, 0, 0, lat);
      check("poke_ignored", bus.rdata_out, 32'h0);

      // Reset during MEM_RESP aborts the load
      do_req(0, 2'd2, 0, 32'h10, 0, 0, lat);
      bus.req_valid = 1; bus.req_write = 0; bus.req_size = 2'd2; bus.addr_in = 32'h10;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 0;
      @(negedge clk);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst_n = 0;
      @(negedge clk);
      check("rst_done", 32'(bus.done), 32'd0);  check("rst_rdata", bus.rdata_out, 32'h0);
      check("rst_en", 32'(bus.mem_en), 32'd0);  check("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      do_req(0, 2'd0, 1, 32'h13, 0, 0, lat);
      check("post_rst_lbu", bus.rdata_out, 32'h0000_0080);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
